// File: rtl/regfile_wb.sv
// Dual register file (integer + floating point) with a single write-back port,
// combinational reads with write-through bypass, and a saturating write counter.
module regfile_wb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              regwr,
    input  logic [ADDR_W-1:0] rw,
    input  logic [DATA_W-1:0] busW,
    input  logic [1:0]        fpoint,
    input  logic [ADDR_W-1:0] ra,
    input  logic [ADDR_W-1:0] rb,
    output logic [DATA_W-1:0] busA,
    output logic [DATA_W-1:0] busB,
    input  logic [ADDR_W-1:0] fa,
    input  logic [ADDR_W-1:0] fb,
    output logic [DATA_W-1:0] fbusA,
    output logic [DATA_W-1:0] fbusB,
    output logic [15:0]       wr_count
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] ireg_q [DEPTH];
    logic [DATA_W-1:0] ireg_d [DEPTH];
    logic [DATA_W-1:0] freg_q [DEPTH];
    logic [DATA_W-1:0] freg_d [DEPTH];
    logic [15:0]       wr_count_q;
    logic [15:0]       wr_count_d;

    logic              fp_sel_s;
    logic              fpoint_unused_s;
    logic              int_wr_s;
    logic              fp_wr_s;
    logic              eff_wr_s;
    logic [DATA_W-1:0] busa_s;
    logic [DATA_W-1:0] busb_s;
    logic [DATA_W-1:0] fbusa_s;
    logic [DATA_W-1:0] fbusb_s;

    // Only bit0 of fpoint selects the file; bit1 is carried but has no effect.
    assign fp_sel_s        = fpoint[0];
    assign fpoint_unused_s = fpoint[1];

    // Decode which file (if any) takes an effective write this cycle.
    always_comb begin
        int_wr_s = 1'b0;
        fp_wr_s  = 1'b0;
        if (regwr) begin
            if (fp_sel_s) begin
                fp_wr_s = 1'b1;
            end else begin
                int_wr_s = (rw != {ADDR_W{1'b0}});
            end
        end else begin
            int_wr_s = 1'b0;
            fp_wr_s  = 1'b0;
        end
        eff_wr_s = int_wr_s | fp_wr_s;
    end

    // Next-state for both arrays and the saturating write counter.
    always_comb begin
        ireg_d     = ireg_q;
        freg_d     = freg_q;
        wr_count_d = wr_count_q;
        if (int_wr_s) begin
            ireg_d[rw] = busW;
        end else if (fp_wr_s) begin
            freg_d[rw] = busW;
        end else begin
            ireg_d = ireg_q;
        end
        if (eff_wr_s && (wr_count_q != 16'hFFFF)) begin
            wr_count_d = wr_count_q + 16'd1;
        end else begin
            wr_count_d = wr_count_q;
        end
    end

    // Storage and counter; reset clears every entry asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                ireg_q[i] <= {DATA_W{1'b0}};
                freg_q[i] <= {DATA_W{1'b0}};
            end
            wr_count_q <= 16'd0;
        end else begin
            ireg_q     <= ireg_d;
            freg_q     <= freg_d;
            wr_count_q <= wr_count_d;
        end
    end

    // Read port mux: an effective write to the same index wins over storage.
    always_comb begin
        busa_s  = ireg_q[ra];
        busb_s  = ireg_q[rb];
        fbusa_s = freg_q[fa];
        fbusb_s = freg_q[fb];
        if (int_wr_s && (rw == ra)) begin
            busa_s = busW;
        end else begin
            busa_s = ireg_q[ra];
        end
        if (int_wr_s && (rw == rb)) begin
            busb_s = busW;
        end else begin
            busb_s = ireg_q[rb];
        end
        if (fp_wr_s && (rw == fa)) begin
            fbusa_s = busW;
        end else begin
            fbusa_s = freg_q[fa];
        end
        if (fp_wr_s && (rw == fb)) begin
            fbusb_s = busW;
        end else begin
            fbusb_s = freg_q[fb];
        end
    end

    // Reads are zero-latency; while in reset they are forced to zero so a
    // pending bypass cannot leak through.
    assign busA     = rst_n ? busa_s  : {DATA_W{1'b0}};
    assign busB     = rst_n ? busb_s  : {DATA_W{1'b0}};
    assign fbusA    = rst_n ? fbusa_s : {DATA_W{1'b0}};
    assign fbusB    = rst_n ? fbusb_s : {DATA_W{1'b0}};
    assign wr_count = wr_count_q;

endmodule
